// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: in-order instruction fetch front end with a FIFO toward decode.
//   clk, rst_n                         : clock, asynchronous active-low reset
//   imem_req_valid/ready/addr          : word-aligned fetch request channel
//   imem_rsp_valid/data                : in-order response words
//   redirect_valid/redirect_pc         : branch/jump redirect pulse and target
//   instr_valid/ready, instr, instr_pc : FIFO head toward decode
//   perf_fetched/perf_discarded        : saturating counters, only with IFU_PERF_CNT_EN
module instr_fetch_unit #(
   parameter int              XLEN       = 32,
   parameter logic [XLEN-1:0] RESET_PC   = '0,
   parameter int              FIFO_DEPTH = 4
) (
   input  logic            clk,
   input  logic            rst_n,
   output logic            imem_req_valid,
   input  logic            imem_req_ready,
   output logic [XLEN-1:0] imem_req_addr,
   input  logic            imem_rsp_valid,
   input  logic [XLEN-1:0] imem_rsp_data,
   input  logic            redirect_valid,
   input  logic [XLEN-1:0] redirect_pc,
   output logic            instr_valid,
   input  logic            instr_ready,
   output logic [XLEN-1:0] instr,
   output logic [XLEN-1:0] instr_pc
`ifdef IFU_PERF_CNT_EN
   ,
   output logic [31:0]     perf_fetched,
   output logic [31:0]     perf_discarded
`endif
);
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int CW = AW + 1;
   typedef enum logic [1:0] {IDLE, FETCH, DRAIN} state_t;
   state_t          state, state_next;
   logic [XLEN-1:0] fetch_pc, rsp_pc, target;
   logic [CW-1:0]   outstanding, out_next, drop, count;
   logic [AW-1:0]   rd_ptr, wr_ptr;
   logic [XLEN-1:0] fifo_data [FIFO_DEPTH];
   logic [XLEN-1:0] fifo_pc   [FIFO_DEPTH];
   logic            acc, pop, push;
   // Credit rule: requests in flight plus buffered words never exceed the FIFO size,
   // so every response always finds a free slot.
   assign imem_req_valid = state == FETCH && ({1'b0, outstanding} + {1'b0, count} < (CW+1)'(FIFO_DEPTH));
   assign imem_req_addr  = fetch_pc;
   assign instr_valid    = count != '0;
   assign instr          = instr_valid ? fifo_data[rd_ptr] : '0;
   assign instr_pc       = instr_valid ? fifo_pc[rd_ptr] : '0;
   assign acc            = imem_req_valid && imem_req_ready;
   assign pop            = instr_valid && instr_ready;
   assign push           = imem_rsp_valid && state == FETCH && !redirect_valid;
   assign out_next       = outstanding + CW'(acc) - CW'(imem_rsp_valid);
   assign target         = {redirect_pc[XLEN-1:2], 2'b00};
   always_comb begin
      state_next = state;
      state_next = redirect_valid ? (out_next != '0 ? DRAIN : FETCH)
                 : state == IDLE ? FETCH
                 : (state == DRAIN && imem_rsp_valid && drop == CW'(1)) ? FETCH
                 : state;
   end
   // After a redirect every outstanding request is stale, so the PC of the next
   // useful response is simply the redirect target; no per-request tag is needed.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         fetch_pc    <= RESET_PC;
         rsp_pc      <= RESET_PC;
         outstanding <= '0;
         drop        <= '0;
         count       <= '0;
         rd_ptr      <= '0;
         wr_ptr      <= '0;
      end else begin
         state       <= state_next;
         outstanding <= out_next;
         if (redirect_valid) begin
            fetch_pc <= target;
            rsp_pc   <= target;
            drop     <= out_next;
            count    <= '0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
         end else begin
            if (acc) fetch_pc <= fetch_pc + XLEN'(4);
            if (state == DRAIN && imem_rsp_valid) drop <= drop - CW'(1);
            if (push) begin
               wr_ptr <= wr_ptr + AW'(1);
               rsp_pc <= rsp_pc + XLEN'(4);
            end
            if (pop) rd_ptr <= rd_ptr + AW'(1);
            count <= count + CW'(push) - CW'(pop);
         end
      end
   end
   always_ff @(posedge clk) begin
      if (push) begin
         fifo_data[wr_ptr] <= imem_rsp_data;
         fifo_pc[wr_ptr]   <= rsp_pc;
      end
   end
`ifdef IFU_PERF_CNT_EN
   function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [31:0] b);
      logic [32:0] s;
      s = {1'b0, a} + {1'b0, b};
      return s[32] ? 32'hFFFF_FFFF : s[31:0];
   endfunction
   logic [31:0] disc_inc;
   // A word popped in the redirect cycle was delivered, so it is not counted as flushed.
   assign disc_inc = redirect_valid ? 32'(count) - 32'(pop) + 32'(imem_rsp_valid)
                                    : 32'(state == DRAIN && imem_rsp_valid);
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         perf_fetched   <= '0;
         perf_discarded <= '0;
      end else begin
         perf_fetched   <= sat_add(perf_fetched, 32'(pop));
         perf_discarded <= sat_add(perf_discarded, disc_inc);
      end
   end
`endif
endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb_instr_fetch_unit: randomized bench for instr_fetch_unit against a queue-based model.
module tb_instr_fetch_unit;
   localparam logic [31:0] K = 32'hA5A5_0000;
   logic        clk = 0, rst_n = 0;
   logic        imem_req_valid, imem_req_ready = 0;
   logic [31:0] imem_req_addr;
   logic        imem_rsp_valid = 0;
   logic [31:0] imem_rsp_data = 0;
   logic        redirect_valid = 0;
   logic [31:0] redirect_pc = 0;
   logic        instr_valid, instr_ready = 0;
   logic [31:0] instr, instr_pc;
`ifdef IFU_PERF_CNT_EN
   logic [31:0] perf_fetched, perf_discarded;
`endif
   instr_fetch_unit dut (
      .clk(clk), .rst_n(rst_n),
      .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_req_addr(imem_req_addr),
      .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
      .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
      .instr_valid(instr_valid), .instr_ready(instr_ready), .instr(instr), .instr_pc(instr_pc)
`ifdef IFU_PERF_CNT_EN
      , .perf_fetched(perf_fetched), .perf_discarded(perf_discarded)
`endif
   );
   always #5 clk = ~clk;
   typedef struct {logic [31:0] addr; int due; bit stale;} req_t;
   req_t        memq[$];
   logic [31:0] fifoq[$];
   int          vectors = 0, miscompares = 0;
   int          cyc, lat_min, lat_max, n_acc, n_pop;
   logic [31:0] exp_req, last_acc, first_pop, prev_addr;
   bit          prev_stall, wrap_seen;
   longint      exp_fetched, exp_disc;
   function automatic int stale_cnt();
      int n = 0;
      foreach (memq[i]) if (memq[i].stale) n++;
      return n;
   endfunction
   // One clock cycle, starting and ending at a falling edge.
   task automatic cycle();
      bit acc, pop, rsp;
      req_t r;
      rsp = 0;
      imem_rsp_valid = 0;
      imem_rsp_data  = 0;
      if (memq.size() > 0 && memq[0].due <= cyc) begin
         rsp = 1;
         imem_rsp_valid = 1;
         imem_rsp_data  = memq[0].addr ^ K;
      end
      #1;
      vectors++;
      if (instr_valid !== (fifoq.size() > 0)) begin
         miscompares++;
         $display("FAIL valid cyc=%0d got %b want %b", cyc, instr_valid, fifoq.size() > 0);
      end
      if (instr_valid === 1'b1 && fifoq.size() > 0) begin
         vectors++;
         if (instr_pc !== fifoq[0] || instr !== (fifoq[0] ^ K)) begin
            miscompares++;
            $display("FAIL head cyc=%0d got pc=%h instr=%h want pc=%h instr=%h", cyc, instr_pc, instr, fifoq[0], fifoq[0] ^ K);
         end
      end
      if (prev_stall) begin
         vectors++;
         if (imem_req_valid !== 1'b1 || imem_req_addr !== prev_addr) begin
            miscompares++;
            $display("FAIL hold cyc=%0d got v=%b a=%h want v=1 a=%h", cyc, imem_req_valid, imem_req_addr, prev_addr);
         end
      end
      acc = imem_req_valid === 1'b1 && imem_req_ready;
      pop = instr_valid === 1'b1 && instr_ready;
      if (acc) begin
         vectors++;
         if (imem_req_addr !== exp_req || stale_cnt() > 0 || memq.size() + fifoq.size() >= 4) begin
            miscompares++;
            $display("FAIL req cyc=%0d got a=%h inflight=%0d stale=%0d want a=%h credit<4", cyc, imem_req_addr, memq.size() + fifoq.size(), stale_cnt(), exp_req);
         end
         if (last_acc == 32'hFFFF_FFFC && imem_req_addr == 32'h0) wrap_seen = 1;
         last_acc = imem_req_addr;
         exp_req += 4;
         n_acc++;
      end
      if (pop && fifoq.size() > 0) begin
         if (n_pop == 0) first_pop = instr_pc;
         void'(fifoq.pop_front());
         n_pop++;
         exp_fetched++;
      end
      if (rsp) begin
         r = memq.pop_front();
         if (!r.stale && !redirect_valid) fifoq.push_back(r.addr);
         else exp_disc++;
      end
      if (acc) begin
         r.addr  = imem_req_addr;
         r.due   = cyc + $urandom_range(lat_max, lat_min);
         r.stale = 0;
         memq.push_back(r);
      end
      if (redirect_valid) begin
         exp_disc += fifoq.size();
         fifoq.delete();
         foreach (memq[i]) memq[i].stale = 1;
         exp_req = {redirect_pc[31:2], 2'b00};
      end
      prev_stall = imem_req_valid === 1'b1 && !imem_req_ready && !redirect_valid;
      prev_addr  = imem_req_addr;
      @(posedge clk);
      @(negedge clk);
      redirect_valid = 0;
      cyc++;
   endtask
   task automatic do_reset();
      @(negedge clk);
      rst_n = 0;
      imem_req_ready = 0; instr_ready = 0; redirect_valid = 0;
      imem_rsp_valid = 0; imem_rsp_data = 0;
      memq.delete(); fifoq.delete();
      exp_req = 0; last_acc = 0; prev_stall = 0; wrap_seen = 0;
      exp_fetched = 0; exp_disc = 0;
      n_acc = 0; n_pop = 0; cyc = 0; lat_min = 1; lat_max = 1;
      @(negedge clk);
      rst_n = 1;
      @(negedge clk);
   endtask
   task automatic test_reset();
      @(negedge clk);
      rst_n = 0;
      #2;
      vectors++;
      if (imem_req_valid !== 0 || instr_valid !== 0 || instr !== 0 || instr_pc !== 0) begin
         miscompares++;
         $display("FAIL reset got rv=%b iv=%b instr=%h pc=%h want 0", imem_req_valid, instr_valid, instr, instr_pc);
      end
`ifdef IFU_PERF_CNT_EN
      vectors++;
      if (perf_fetched !== 0 || perf_discarded !== 0) begin
         miscompares++;
         $display("FAIL perf_reset got %0d %0d want 0 0", perf_fetched, perf_discarded);
      end
`endif
      @(negedge clk);
      rst_n = 1;
      #1;
      vectors++;
      if (imem_req_valid !== 0) begin
         miscompares++;
         $display("FAIL idle got rv=%b want 0", imem_req_valid);
      end
      @(negedge clk);
      vectors++;
      if (imem_req_valid !== 1 || imem_req_addr !== 0) begin
         miscompares++;
         $display("FAIL first_req got v=%b a=%h want v=1 a=0", imem_req_valid, imem_req_addr);
      end
   endtask
   task automatic test_stream();
      do_reset();
      imem_req_ready = 1; instr_ready = 1;
      repeat (20) cycle();
      vectors++;
      if (n_pop != 18) begin
         miscompares++;
         $display("FAIL stream got %0d pops want 18", n_pop);
      end
   endtask
   task automatic test_stall();
      do_reset();
      imem_req_ready = 1; instr_ready = 0;
      repeat (20) cycle();
      vectors++;
      if (n_acc != 4 || instr_valid !== 1 || instr_pc !== 0) begin
         miscompares++;
         $display("FAIL stall got acc=%0d v=%b pc=%h want acc=4 v=1 pc=0", n_acc, instr_valid, instr_pc);
      end
      instr_ready = 1;
      repeat (10) cycle();
      vectors++;
      if (n_pop < 4 || n_acc < 5) begin
         miscompares++;
         $display("FAIL resume got pops=%0d acc=%0d want >=4 >=5", n_pop, n_acc);
      end
   endtask
   task automatic test_req_stall();
      do_reset();
      imem_req_ready = 0; instr_ready = 1;
      repeat (3) begin
         vectors++;
         if (imem_req_valid !== 1 || imem_req_addr !== 0) begin
            miscompares++;
            $display("FAIL req_stall got v=%b a=%h want v=1 a=0", imem_req_valid, imem_req_addr);
         end
         cycle();
      end
      imem_req_ready = 1;
      cycle();
      vectors++;
      if (n_acc != 1 || last_acc !== 0) begin
         miscompares++;
         $display("FAIL req_release got acc=%0d a=%h want 1 0", n_acc, last_acc);
      end
   endtask
   task automatic test_drain();
      do_reset();
      lat_min = 3; lat_max = 3;
      imem_req_ready = 1; instr_ready = 1;
      repeat (3) cycle();
      imem_req_ready = 0;
      redirect_valid = 1; redirect_pc = 32'h102;
      cycle();
      imem_req_ready = 1; lat_min = 1; lat_max = 1;
      for (int i = 0; i < 20 && n_pop == 0; i++) cycle();
      vectors++;
      if (n_pop == 0 || first_pop !== 32'h100) begin
         miscompares++;
         $display("FAIL drain got pops=%0d first=%h want first=00000100", n_pop, first_pop);
      end
`ifdef IFU_PERF_CNT_EN
      vectors++;
      if (perf_discarded !== 3 || perf_fetched !== 32'(exp_fetched)) begin
         miscompares++;
         $display("FAIL perf_drain got disc=%0d fet=%0d want 3 %0d", perf_discarded, perf_fetched, exp_fetched);
      end
`endif
   endtask
   task automatic test_redirect_pop();
      do_reset();
      imem_req_ready = 1; instr_ready = 1;
      repeat (6) cycle();
      n_pop = 0;
      redirect_valid = 1; redirect_pc = 32'h300;
      cycle();
      vectors++;
      if (n_pop != 1 || instr_valid !== 0) begin
         miscompares++;
         $display("FAIL redirect_pop got pops=%0d v=%b want 1 0", n_pop, instr_valid);
      end
      lat_min = 3; lat_max = 3;
      repeat (3) cycle();
      redirect_valid = 1; redirect_pc = 32'h400;
      cycle();
      vectors++;
      if (imem_req_valid !== 0) begin
         miscompares++;
         $display("FAIL drain_state got rv=%b want 0", imem_req_valid);
      end
      redirect_valid = 1; redirect_pc = 32'h200;
      cycle();
      n_pop = 0; n_acc = 0; lat_min = 1; lat_max = 1;
      for (int i = 0; i < 30 && n_pop == 0; i++) cycle();
      vectors++;
      if (n_pop == 0 || first_pop !== 32'h200) begin
         miscompares++;
         $display("FAIL drain_redirect got pops=%0d first=%h want first=00000200", n_pop, first_pop);
      end
   endtask
   task automatic test_wrap();
      do_reset();
      imem_req_ready = 1; instr_ready = 1;
      redirect_valid = 1; redirect_pc = 32'hFFFF_FFF8;
      cycle();
      n_pop = 0;
      repeat (12) cycle();
      vectors++;
      if (!wrap_seen || n_pop < 6) begin
         miscompares++;
         $display("FAIL wrap got wrap=%0d pops=%0d want 1 >=6", wrap_seen, n_pop);
      end
   endtask
   task automatic test_random();
      do_reset();
      lat_min = 1; lat_max = 4;
      repeat (800) begin
         imem_req_ready = $urandom_range(3, 0) != 0;
         instr_ready    = $urandom_range(2, 0) != 0;
         redirect_valid = $urandom_range(29, 0) == 0;
         redirect_pc    = $urandom;
         cycle();
      end
      vectors++;
      if (n_pop < 100) begin
         miscompares++;
         $display("FAIL random_progress got %0d pops want >=100", n_pop);
      end
`ifdef IFU_PERF_CNT_EN
      vectors++;
      if (perf_fetched !== 32'(exp_fetched) || perf_discarded !== 32'(exp_disc)) begin
         miscompares++;
         $display("FAIL perf_random got %0d %0d want %0d %0d", perf_fetched, perf_discarded, exp_fetched, exp_disc);
      end
`endif
   endtask
   initial begin
      test_reset();
      test_stream();
      test_stall();
      test_req_stall();
      test_drain();
      test_redirect_pop();
      test_wrap();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
   initial begin
      #500000;
      $display("FAIL timeout");
      $fatal(1);
   end
endmodule
